// File: rtl/scan_test_controller_pkg.sv
// Shared definitions for the scan test controller: FSM state encoding and counter sizing.
package scan_test_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_UNLOAD  = 3'd4,
      ST_FINISH  = 3'd5
   } state_t;

   // Counter width for a count range of n; a one-entry range still needs a 1-bit register.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scan_test_controller_step_counter.sv
// Wrapping step counter with synchronous clear and a terminal-count flag.
module scan_step_counter #(
   parameter int WIDTH    = 4,
   parameter int TERMINAL = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [WIDTH-1:0] LP_TC = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] r_count;

   // Count enabled steps, wrapping to zero after the terminal value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         if (r_count == LP_TC) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + WIDTH'(1);
         end
      end else begin
         r_count <= r_count;
      end
   end

   assign o_tc = (r_count == LP_TC);

endmodule

// File: rtl/scan_test_controller.sv
// Mux-scan chain sequencer: load, capture, shift/unload for a programmed number of patterns,
// with valid/ready stimulus and response streams and a gated chain clock.
module scan_test_controller
   import scan_test_controller_pkg::*;
#(
   parameter int CHAIN_LENGTH   = 16,
   parameter int CAPTURE_CYCLES = 1,
   parameter int PCNT_W         = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [PCNT_W-1:0] i_pattern_count,
   input  logic              i_pat_valid,
   input  logic              i_pat_bit,
   output logic              o_pat_ready,
   output logic              o_rsp_valid,
   output logic              o_rsp_bit,
   input  logic              i_rsp_ready,
   input  logic              i_scan_out,
   output logic              o_scan_in,
   output logic              o_scan_enable,
   output logic              o_chain_clk_en,
   output logic              o_busy,
   output logic              o_done
);

   localparam int CNT_W = cnt_w(CHAIN_LENGTH);
   localparam int CAP_W = cnt_w(CAPTURE_CYCLES);

   state_t            r_state;
   logic [PCNT_W-1:0] r_remaining;

   logic w_step;
   logic w_scan_en;
   logic w_pat_path;
   logic w_rsp_valid;
   logic w_abort;
   logic w_step_go;
   logic w_in_cap;
   logic w_cnt_clr;
   logic w_bit_tc;
   logic w_cap_tc;
   logic w_last_bit;
   logic w_last_cap;
   logic [PCNT_W-1:0] w_rem_dec;

   // Per-state decode of the step condition and the datapath selects.
   always_comb begin
      w_step      = 1'b0;
      w_scan_en   = 1'b0;
      w_pat_path  = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_step     = i_pat_valid;
            w_scan_en  = 1'b1;
            w_pat_path = 1'b1;
         end
         ST_SHIFT: begin
            w_step      = i_pat_valid & i_rsp_ready;
            w_scan_en   = 1'b1;
            w_pat_path  = 1'b1;
            w_rsp_valid = i_pat_valid;
         end
         ST_UNLOAD: begin
            w_step      = i_rsp_ready;
            w_scan_en   = 1'b1;
            w_rsp_valid = 1'b1;
         end
         default: begin
            w_step = 1'b0;
         end
      endcase
   end

   // Abort outranks everything, so it also suppresses the step of its own cycle.
   assign w_abort    = i_abort & (r_state != ST_IDLE);
   assign w_step_go  = w_step & ~w_abort;
   assign w_in_cap   = (r_state == ST_CAPTURE);
   assign w_cnt_clr  = (r_state == ST_IDLE) | w_abort;
   assign w_last_bit = w_step_go & w_bit_tc;
   assign w_last_cap = w_in_cap & w_cap_tc;
   assign w_rem_dec  = r_remaining - PCNT_W'(1);

   scan_step_counter #(
      .WIDTH    (CNT_W),
      .TERMINAL (CHAIN_LENGTH - 1)
   ) u_bit_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_cnt_clr),
      .i_en    (w_step_go),
      .o_tc    (w_bit_tc)
   );

   scan_step_counter #(
      .WIDTH    (CAP_W),
      .TERMINAL (CAPTURE_CYCLES - 1)
   ) u_cap_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_cnt_clr),
      .i_en    (w_in_cap & ~w_abort),
      .o_tc    (w_cap_tc)
   );

   // Session FSM with the inline remaining-pattern counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
      end else if (w_abort) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_remaining <= i_pattern_count;
                  r_state     <= (i_pattern_count == '0) ? ST_FINISH : ST_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               r_state <= w_last_bit ? ST_CAPTURE : ST_LOAD;
            end
            ST_CAPTURE: begin
               if (w_last_cap) begin
                  r_remaining <= w_rem_dec;
                  r_state     <= (w_rem_dec != '0) ? ST_SHIFT : ST_UNLOAD;
               end else begin
                  r_state <= ST_CAPTURE;
               end
            end
            ST_SHIFT: begin
               r_state <= w_last_bit ? ST_CAPTURE : ST_SHIFT;
            end
            ST_UNLOAD: begin
               r_state <= w_last_bit ? ST_FINISH : ST_UNLOAD;
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_pat_ready    = w_step_go & w_pat_path;
   assign o_chain_clk_en = (w_step_go | w_in_cap) & ~w_abort;
   assign o_scan_enable  = w_scan_en;
   assign o_scan_in      = w_pat_path & i_pat_bit;
   assign o_rsp_valid    = w_rsp_valid;
   assign o_rsp_bit      = i_scan_out & (r_state != ST_IDLE);
   assign o_busy         = (r_state != ST_IDLE);
   assign o_done         = (r_state == ST_FINISH);

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: 4-flop chain model whose capture inverts every flop,
// per-cycle output tables and a response scoreboard fed from the accepted stimulus bits.
module tb_scan_test_controller;

   typedef struct {
      int         n;
      logic       st;
      logic       ab;
      logic       pv;
      logic       rr;
      logic [15:0] pc;
      logic [5:0] exp;
   } seg_t;

   // {busy, done, scan_enable, chain_clk_en, pat_ready, rsp_valid}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_LOAD  = 6'b101110;
   localparam logic [5:0] O_CAP   = 6'b100100;
   localparam logic [5:0] O_SHIFT = 6'b101111;
   localparam logic [5:0] O_STALL = 6'b101001;
   localparam logic [5:0] O_UNLD  = 6'b101101;
   localparam logic [5:0] O_FIN   = 6'b110000;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, pat_valid, pat_bit, rsp_ready;
   logic [15:0] pattern_count;
   logic        pat_ready, rsp_valid, rsp_bit, scan_out, scan_in;
   logic        scan_enable, chain_clk_en, busy, done;
   logic [3:0]  chain = 4'b1111;
   logic [5:0]  obs;

   int   n_tests = 0;
   int   n_fail  = 0;
   seg_t tbl[$];
   logic stim[$];
   logic sb[$];
   int   sidx;

   always #5 clk = ~clk;

   scan_test_controller #(
      .CHAIN_LENGTH   (4),
      .CAPTURE_CYCLES (1),
      .PCNT_W         (16)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_start         (start),
      .i_abort         (abort),
      .i_pattern_count (pattern_count),
      .i_pat_valid     (pat_valid),
      .i_pat_bit       (pat_bit),
      .o_pat_ready     (pat_ready),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_bit       (rsp_bit),
      .i_rsp_ready     (rsp_ready),
      .i_scan_out      (scan_out),
      .o_scan_in       (scan_in),
      .o_scan_enable   (scan_enable),
      .o_chain_clk_en  (chain_clk_en),
      .o_busy          (busy),
      .o_done          (done)
   );

   // Chain model: shift toward the last flop when selected, invert on capture.
   always @(posedge clk) begin
      if (chain_clk_en) chain <= scan_enable ? {chain[2:0], scan_in} : ~chain;
   end
   assign scan_out = chain[3];
   assign obs = {busy, done, scan_enable, chain_clk_en, pat_ready, rsp_valid};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int n, input logic st, input logic ab, input logic pv,
                      input logic rr, input logic [15:0] pc, input logic [5:0] exp);
      tbl.push_back('{n, st, ab, pv, rr, pc, exp});
   endtask

   task automatic set_stim(input logic [3:0] p1, input logic [3:0] p2);
      stim.delete();
      sb.delete();
      sidx = 0;
      for (int b = 0; b < 4; b++) stim.push_back(p1[b]);
      for (int b = 0; b < 4; b++) stim.push_back(p2[b]);
   endtask

   // Apply a segment table cycle by cycle; entered and left at posedge+1.
   task automatic run_table(input string name, input bit want_empty);
      int  cyc = 0;
      int  nr  = 0;
      logic acc;
      logic e;
      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            start         = tbl[i].st;
            abort         = tbl[i].ab;
            pat_valid     = tbl[i].pv;
            rsp_ready     = tbl[i].rr;
            pattern_count = tbl[i].pc;
            pat_bit       = (sidx < stim.size()) ? stim[sidx] : 1'b0;
            @(negedge clk);
            check($sformatf("%s cyc%0d outs", name, cyc), {26'd0, obs}, {26'd0, tbl[i].exp});
            acc = pat_valid & pat_ready;
            if (acc) sb.push_back(~pat_bit);
            if (rsp_valid & rsp_ready) begin
               if (sb.size() == 0) begin
                  check($sformatf("%s rsp%0d unexpected", name, nr), 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("%s rsp%0d", name, nr), {31'd0, rsp_bit}, {31'd0, e});
               end
               nr++;
            end
            @(posedge clk);
            #1;
            if (acc) sidx++;
            cyc++;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      if (want_empty) check({name, " sb_empty"}, sb.size(), 32'd0);
      tbl.delete();
   endtask

   task automatic build_normal();
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_LOAD);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_CAP);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_SHIFT);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_CAP);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_UNLD);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_FIN);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; pat_valid = 1'b0;
      pat_bit = 1'b1; rsp_ready = 1'b0; pattern_count = 16'd2; sidx = 0;

      // 1: reset while START is high, then quiet release
      #12;
      check("reset outs", {24'd0, obs, rsp_bit, scan_in}, 32'd0);
      @(posedge clk); #1;
      check("reset outs after edge", {24'd0, obs, rsp_bit, scan_in}, 32'd0);
      start = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("post-reset idle%0d", c), {26'd0, obs}, 32'd0);
      end
      @(posedge clk); #1;

      // 2: two patterns, free-flowing handshakes
      set_stim(4'b1010, 4'b0011);
      build_normal();
      run_table("t2", 1'b1);

      // 3: RSP_READY low for three cycles at SHIFT bit 2
      set_stim(4'b0110, 4'b1001);
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_LOAD);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_CAP);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_SHIFT);
      add(3, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, O_STALL);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_SHIFT);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_CAP);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_UNLD);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_FIN);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
      run_table("t3", 1'b1);

      // 4: zero patterns
      set_stim(4'b0000, 4'b0000);
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, O_IDLE);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, O_FIN);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, O_IDLE);
      run_table("t4", 1'b1);

      // 5a: abort at SHIFT bit 2, then a clean session
      set_stim(4'b1111, 4'b0000);
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_LOAD);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_CAP);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_SHIFT);
      add(1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2, O_STALL);
      add(3, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
      run_table("t5 abort", 1'b0);
      set_stim(4'b1010, 4'b0011);
      build_normal();
      run_table("t5 clean", 1'b1);

      // 5b: asynchronous reset in the middle of LOAD
      start = 1'b1; pattern_count = 16'd1; pat_valid = 1'b1; rsp_ready = 1'b1; pat_bit = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("t5 load before reset", {26'd0, obs}, {26'd0, O_LOAD});
      #2 rst_n = 1'b0;
      #1;
      check("t5 async reset outs", {24'd0, obs, rsp_bit, scan_in}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("t5 idle after reset", {26'd0, obs}, 32'd0);
      @(posedge clk); #1;

      // 6: START during SHIFT and FINISH, PATTERN_COUNT changed during LOAD
      set_stim(4'b1100, 4'b0101);
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, O_IDLE);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_LOAD);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_CAP);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_SHIFT);
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd7, O_SHIFT);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_SHIFT);
      add(1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_CAP);
      add(4, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_UNLD);
      add(1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd7, O_FIN);
      add(2, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7, O_IDLE);
      run_table("t6", 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
